// File: rtl/mantissa_multiplier_seq.sv
// mantissa_multiplier_seq: radix-2 shift-and-add unsigned multiplier, one multiplier bit per clock
module mantissa_multiplier_seq #(
   parameter int WIDTH = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   m_q, m_d, q_q, q_d;
   logic [WIDTH:0]     acc_q, acc_d, sum;
   logic [2*WIDTH-1:0] product_q, product_d;
   logic               busy_q, busy_d, done_q, done_d;
   always_comb begin
      sum       = acc_q + (q_q[0] ? {1'b0, m_q} : '0);
      state_d   = state_q;
      cnt_d     = cnt_q;
      m_d       = m_q;
      q_d       = q_q;
      acc_d     = acc_q;
      product_d = product_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            m_d     = a;
            q_d     = b;
            acc_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            // guard bit of sum carries into A's MSB as the pair shifts right
            {acc_d, q_d} = {sum, q_q} >> 1;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1)) begin
               product_d = {acc_d[WIDTH-1:0], q_d};
               done_d    = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         m_q       <= '0;
         q_q       <= '0;
         acc_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         m_q       <= m_d;
         q_q       <= q_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end
   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;
endmodule

// File: tb/tb_mantissa_multiplier_seq.sv
// tb_mantissa_multiplier_seq: directed vector table, multi-cycle corner sequences and
// randomized back-to-back operations against an arithmetic reference
module tb_mantissa_multiplier_seq;
   localparam int W = 24;
   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           start = 1'b0;
   logic [W-1:0]   a = '0, b = '0;
   logic           busy, done;
   logic [2*W-1:0] product;
   int             checks = 0, errors = 0;

   mantissa_multiplier_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
      .busy(busy), .done(done), .product(product)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0]   va;
      logic [W-1:0]   vb;
      logic [2*W-1:0] exp;
   } vec_t;

   function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
      longint unsigned r;
      r = longint'(x) * longint'(y);
      return r[2*W-1:0];
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // returns the cycle (capture edge = cycle 0) in which done is seen, -1 on timeout
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        output logic [2*W-1:0] p, output int lat);
      @(negedge clk);
      a = ta; b = tbv; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = W'($urandom); b = W'($urandom);
      lat = -1; p = '0;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         @(posedge clk); #1;
         if (done) begin
            lat = k + 1;
            p = product;
         end
      end
      repeat (2) @(posedge clk);
      #1;
   endtask

   vec_t           vecs[$];
   logic [2*W-1:0] p, p0;
   int             lat, dn, n;
   logic           busy_ok;
   logic [W-1:0]   ea, eb;

   initial begin
      vecs.push_back('{24'h800000, 24'h800000, 48'h4000_0000_0000});
      vecs.push_back('{24'hFFFFFF, 24'hFFFFFF, 48'hFFFF_FE00_0001});
      vecs.push_back('{24'd3,      24'd5,      48'd15});
      vecs.push_back('{24'd0,      24'hABCDEF, 48'd0});
      vecs.push_back('{24'd1,      24'd1,      48'd1});
      vecs.push_back('{24'hFFFFFF, 24'd1,      48'h0000_00FF_FFFF});
      vecs.push_back('{24'h800000, 24'hFFFFFF, 48'h7FFF_FF80_0000});
      vecs.push_back('{24'h123456, 24'h000100, 48'h0000_1234_5600});

      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_done", 64'(done), 64'd0);
      check("reset_product", 64'(product), 64'd0);
      @(negedge clk) rst = 1'b0;

      foreach (vecs[i]) begin
         do_op(vecs[i].va, vecs[i].vb, p, lat);
         check($sformatf("vec%0d_product", i), 64'(p), 64'(vecs[i].exp));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'(W + 1));
      end

      p0 = product;
      repeat (5) @(posedge clk);
      #1;
      check("idle_product_stable", 64'(product), 64'(p0));
      check("idle_busy", 64'(busy), 64'd0);

      // starts during RUN (cycle 5) and DONE (cycle 25) must be ignored
      @(negedge clk);
      a = 24'h000ABC; b = 24'h000123; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; a = 24'hFFFFFF; b = 24'hFFFFFF;
      dn = 0; busy_ok = 1'b1; p = '0;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         if (done) begin
            dn++;
            p = product;
         end
         if (k + 1 <= W + 1 && !busy) busy_ok = 1'b0;
         start = (k + 1 == 5) || (k + 1 == W + 1);
      end
      start = 1'b0;
      check("ignore_done_count", 64'(dn), 64'd1);
      check("ignore_busy_held", 64'(busy_ok), 64'd1);
      check("ignore_product", 64'(p), 64'(ref_mul(24'hABC, 24'h123)));
      check("ignore_end_idle", 64'(busy), 64'd0);

      // asynchronous abort in cycle 10
      @(negedge clk);
      a = 24'h5A5A5A; b = 24'h3C3C3C; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_product", 64'(product), 64'd0);
      @(negedge clk) rst = 1'b0;
      dn = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done) dn++;
      end
      check("abort_no_done", 64'(dn), 64'd0);
      do_op(24'hC0FFEE, 24'hBADBAD, p, lat);
      check("post_abort_product", 64'(p), 64'(ref_mul(24'hC0FFEE, 24'hBADBAD)));
      check("post_abort_latency", 64'(lat), 64'(W + 1));

      // back-to-back with start held high
      @(negedge clk);
      ea = W'($urandom); eb = W'($urandom);
      a = ea; b = eb; start = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < 1000; i++) begin
         n = 0;
         do begin
            @(posedge clk); #1;
            n++;
         end while (!done && n < 60);
         check($sformatf("b2b%0d_product", i), 64'(product), 64'(ref_mul(ea, eb)));
         check($sformatf("b2b%0d_interval", i), 64'(n), i == 0 ? 64'(W) : 64'(W + 2));
         ea = W'($urandom); eb = W'($urandom);
         a = ea; b = eb;
      end
      start = 1'b0;
      repeat (30) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
